lsu_wb: RTL and testbench
=========================

Name: lsu_wb

Overview:
- Load/store unit with writeback formatting.
- Sits directly upstream of the register file write port.
- Accepts one memory op per request from the datapath (address, store data from busB, funct3, rd).
- Drives a valid/grant/rvalid data-memory interface.
- For loads, produces the fully aligned, sign/zero-extended write data plus the write enable and destination for the register file.

Parameters:
- Width, 32, data and address width; only 32 is supported.
- TimeoutCycles, 16, watchdog limit when LSU_TIMEOUT_EN is defined; range 2..255.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- req_valid_i  input  1  datapath presents an op.
- req_ready_o  output  1  LSU can accept; high only in IDLE.
- req_load_i  input  1  1 = load, 0 = store.
- funct3_i  input  3  RV32I width/sign code.
- addr_i  input  Width  byte address.
- wdata_i  input  Width  store data, unaligned (busB).
- rd_i  input  5  load destination.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  Width  word address; {addr[31:2],2'b00}.
- mem_be_o  output  4  byte enables.
- mem_wdata_o  output  Width  lane-replicated store data.
- mem_gnt_i  input  1  request accepted.
- mem_rvalid_i  input  1  read data valid.
- mem_rdata_i  input  Width  read word.
- wb_valid_o  output  1  writeback cycle.
- wb_we_o  output  1  register write enable; wb_valid_o && rd != 0.
- wb_rd_o  output  5  destination register.
- wb_data_o  output  Width  extended load result.
- err_o  output  1  one-cycle error pulse.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset: all outputs 0 except req_ready_o = 1; state = IDLE; captured registers cleared.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - mem_req_o drops asynchronously.
  - No writeback or error is issued.
  - A late mem_gnt_i or mem_rvalid_i is ignored outside REQ/WAIT.
- States: IDLE, REQ, WAIT, WB.
- IDLE: on req_valid_i && req_ready_o, check legality.
  - Illegal funct3:
    - load: 011, 110, 111;
    - store: anything other than 000/001/010.
  - Misaligned:
    - halfword with addr[0] = 1;
    - word with addr[1:0] != 0.
  - Illegal or misaligned: err_o = 1 next cycle, stay IDLE, no memory access.
  - Otherwise capture addr, funct3, rd, req_load_i and formatted store data, then go to REQ.
- REQ:
  - mem_req_o = 1; addr, be, we and wdata held stable until mem_gnt_i.
  - On gnt: store → IDLE (complete at grant, no writeback); load → WAIT.
- WAIT:
  - On mem_rvalid_i: shift rdata right by 8*addr[1:0], extend, register into wb_data_o, go to WB.
  - Extension by funct3:
    - 000 LB: sign from bit 7.
    - 001 LH: sign from bit 15.
    - 010 LW: unmodified.
    - 100 LBU: zero-extend 8 bits.
    - 101 LHU: zero-extend 16 bits.
  - rvalid in the same cycle as gnt is not supported; rvalid is sampled only in WAIT.
- WB:
  - wb_valid_o = 1 for exactly one cycle; wb_we_o as defined above.
  - Go to IDLE; the next request can be accepted in the following cycle.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Minimum latency with gnt in the first REQ cycle and rvalid in the next cycle:
  - Load: accept cycle N, wb_valid_o at N+3.
  - Store: back in IDLE at N+2.
- wb_data_o and wb_rd_o hold their last values outside WB.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and on entry to WAIT, and increments each cycle in those states.
  - On reaching TimeoutCycles without gnt or rvalid respectively: drop mem_req_o, pulse err_o, return to IDLE, no writeback.
- LSU_TIMEOUT_EN undefined:
  - No counter; the LSU waits indefinitely.
  - err_o is raised only for illegal or misaligned requests.

Test Plan:
- LB addr=0x103, rdata=0x80FF_1234, gnt immediate, rvalid next cycle → wb_data_o = 0xFFFF_FF80, wb_we_o = 1, wb_valid_o 3 cycles after accept.
- LHU addr=0x202, rdata=0xBEEF_0000 → wb_data_o = 0x0000_BEEF; LH with the same data → 0xFFFF_BEEF; rd=0 → wb_valid_o = 1, wb_we_o = 0.
- SH addr=0x12, wdata=0xAAAA_5678, gnt delayed 3 cycles → mem_be_o = 4'b1100, mem_wdata_o = 0x5678_5678, mem_addr_o = 0x10, all stable until gnt, no wb_valid_o.
- LW addr=0x06 → err_o pulse one cycle later, mem_req_o never asserted; funct3=011 load → same.
- Reset asserted during WAIT, then rvalid pulsed → no wb_valid_o, req_ready_o = 1 immediately, all outputs at reset values.
- With LSU_TIMEOUT_EN, TimeoutCycles=16, gnt never given → err_o exactly 16 cycles after entering REQ, mem_req_o low afterwards, req_ready_o = 1.

Source files
------------

// File: rtl/lsu_wb.sv
// lsu_wb: RV32I load/store unit with a valid/grant/rvalid memory port and aligned, extended load writeback.
// Define LSU_TIMEOUT_EN to abort REQ/WAIT after TimeoutCycles with an err_o pulse.
module lsu_wb #(
  parameter int Width         = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_load_i,
  input  logic [2:0]       funct3_i,
  input  logic [Width-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [4:0]       rd_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [Width-1:0] mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [Width-1:0] mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [Width-1:0] mem_rdata_i,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [4:0]       wb_rd_o,
  output logic [Width-1:0] wb_data_o,
  output logic             err_o,
  output logic             busy_o
);

  if (Width != 32 || TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_param_check
    $error("lsu_wb: unsupported Width or TimeoutCycles");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t           r_state, w_state_nxt;
  logic [Width-1:0] r_addr, r_wdata, r_wb_data;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd, r_wb_rd;
  logic             r_load, r_we, r_err;
  logic [3:0]       r_be;

  logic             w_accept, w_f3_ok, w_aligned, w_legal, w_timeout, w_abort;
  logic [3:0]       w_be;
  logic [Width-1:0] w_wdata, w_shifted, w_ext;

  assign w_accept  = req_valid_i && (r_state == S_IDLE);
  assign w_f3_ok   = req_load_i ? !(funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)
                                : (!funct3_i[2] && funct3_i[1:0] != 2'b11);
  assign w_aligned = (funct3_i[1:0] == 2'b01) ? !addr_i[0] :
                     (funct3_i[1:0] == 2'b10) ? (addr_i[1:0] == 2'b00) : 1'b1;
  assign w_legal   = w_f3_ok && w_aligned;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    if (!req_load_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr_i[1:0];
          w_wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {addr_i[1], 1'b0};
          w_wdata = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_ext = {16'd0, w_shifted[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Counter restarts whenever the state changes, so it times REQ and WAIT independently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 8'd0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_cnt == 8'(TimeoutCycles - 1)) && (r_state == S_REQ || r_state == S_WAIT);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_abort = w_timeout && ((r_state == S_REQ && !mem_gnt_i) || (r_state == S_WAIT && !mem_rvalid_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_legal) w_state_nxt = S_REQ;
      S_REQ: begin
        if (mem_gnt_i)    w_state_nxt = r_load ? S_WAIT : S_IDLE;
        else if (w_abort) w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rvalid_i) w_state_nxt = S_WB;
        else if (w_abort) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wb_data <= '0;
      r_funct3  <= 3'd0;
      r_rd      <= 5'd0;
      r_wb_rd   <= 5'd0;
      r_load    <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= (w_accept && !w_legal) || w_abort;
      if (w_accept && w_legal) begin
        r_addr   <= addr_i;
        r_wdata  <= w_wdata;
        r_funct3 <= funct3_i;
        r_rd     <= rd_i;
        r_load   <= req_load_i;
        r_we     <= !req_load_i;
        r_be     <= w_be;
      end
      if (r_state == S_WAIT && mem_rvalid_i) begin
        r_wb_data <= w_ext;
        r_wb_rd   <= r_rd;
      end
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = {r_addr[Width-1:2], 2'b00};
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;
  assign wb_valid_o  = (r_state == S_WB);
  assign wb_we_o     = wb_valid_o && (r_wb_rd != 5'd0);
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign err_o       = r_err;

endmodule

// File: tb/tb_lsu_wb.sv
// Randomized and directed bench for lsu_wb against a transaction-level model of the memory op rules.
module tb_lsu_wb;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_load_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [4:0]  rd_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o, wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o, busy_o;

  always #5 clk_i = ~clk_i;

  lsu_wb #(.Width(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_load_i(req_load_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_t;

  req_t        exp_req_q[$];
  wb_t         exp_wb_q[$];
  req_t        cur_req;
  wb_t         cur_wb;
  int          exp_err = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_wb_data = 32'd0;
  logic [4:0]  last_wb_rd = 5'd0;
  logic [31:0] obs_wb_data, obs_addr, obs_wdata, obs_lat;
  logic        obs_wb_we, obs_wb_vld;
  logic [3:0]  obs_be;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model of the op rules ----
  function automatic bit m_legal(input bit ld, input int f3, input int off);
    int sz;
    if (ld && (f3 == 3 || f3 >= 6)) return 1'b0;
    if (!ld && f3 > 2) return 1'b0;
    sz = 1 << (f3 % 4);
    return (off % sz) == 0;
  endfunction

  function automatic logic [3:0] m_be(input bit ld, input int f3, input int off);
    int sz;
    if (ld) return 4'hF;
    sz = 1 << f3;
    return 4'(((1 << sz) - 1) << (off - off % sz));
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = 1 << f3;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ext(input int f3, input int off, input logic [31:0] rdata);
    logic [31:0] sh;
    int bits, v;
    sh = rdata >> (8 * off);
    bits = 8 << (f3 % 4);
    if (bits == 32) return sh;
    v = int'(sh % (32'd1 << bits));
    if (f3 < 4 && v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 32'(v);
  endfunction

  // ---- per-cycle comparison of DUT outputs against the model ----
  always @(negedge clk_i) begin
    if (!rst_i && chk_en) begin
      if (mem_req_o) begin
        if (exp_req_q.size() == 0) begin
          chk("mem_req_unexpected", 32'(mem_req_o), 32'd0);
        end else begin
          cur_req = exp_req_q[0];
          chk("mem_addr", mem_addr_o, cur_req.addr);
          chk("mem_be", 32'(mem_be_o), 32'(cur_req.be));
          chk("mem_we", 32'(mem_we_o), 32'(cur_req.we));
          if (cur_req.we) chk("mem_wdata", mem_wdata_o, cur_req.wdata);
          if (mem_gnt_i) void'(exp_req_q.pop_front());
        end
      end
      if (wb_valid_o) begin
        if (exp_wb_q.size() == 0) begin
          chk("wb_valid_unexpected", 32'(wb_valid_o), 32'd0);
        end else begin
          cur_wb = exp_wb_q.pop_front();
          chk("wb_rd", 32'(wb_rd_o), 32'(cur_wb.rd));
          chk("wb_we", 32'(wb_we_o), 32'(cur_wb.we));
          chk("wb_data", wb_data_o, cur_wb.data);
          last_wb_data = cur_wb.data;
          last_wb_rd   = cur_wb.rd;
        end
      end else begin
        chk("wb_we_idle", 32'(wb_we_o), 32'd0);
        chk("wb_data_hold", wb_data_o, last_wb_data);
        chk("wb_rd_hold", 32'(wb_rd_o), 32'(last_wb_rd));
      end
      if (err_o) begin
        if (exp_err == 0) chk("err_unexpected", 32'(err_o), 32'd0);
        else exp_err--;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be_o), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
    chk({tag, "_wb_we"}, 32'(wb_we_o), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
    chk({tag, "_wb_data"}, wb_data_o, 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  // Drives one op from IDLE (called at posedge+1) and returns at posedge+1 with the DUT idle again.
  task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input int gd, input int rdly, input logic [31:0] rdat);
    int   c0, f3i, off;
    bit   legal;
    req_t r;
    wb_t  w;
    f3i = int'(f3);
    off = int'(a[1:0]);
    legal = m_legal(ld, f3i, off);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    req_valid_i = 1'b1; req_load_i = ld; funct3_i = f3; addr_i = a; wdata_i = wd; rd_i = rd;
    c0 = cyc;
    if (!legal) begin
      exp_err++;
    end else begin
      r.addr = {a[31:2], 2'b00}; r.be = m_be(ld, f3i, off); r.we = !ld; r.wdata = ld ? 32'd0 : m_wdata(f3i, wd);
      exp_req_q.push_back(r);
      if (ld) begin
        w.rd = rd; w.we = (rd != 5'd0); w.data = m_ext(f3i, off, rdat);
        exp_wb_q.push_back(w);
      end
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom); funct3_i = 3'($urandom);
    if (!legal) begin
      chk("err_pulse", 32'(err_o), 32'd1);
      chk("err_no_mem_req", 32'(mem_req_o), 32'd0);
      @(posedge clk_i); #1;
      chk("err_one_cycle", 32'(err_o), 32'd0);
      return;
    end
    chk("busy_in_req", 32'(busy_o), 32'd1);
    chk("not_ready_in_req", 32'(req_ready_o), 32'd0);
    obs_addr = mem_addr_o; obs_be = mem_be_o; obs_wdata = mem_wdata_o;
    repeat (gd) begin @(posedge clk_i); #1; end
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    if (!ld) begin
      obs_lat = 32'(cyc - c0);
      chk("store_idle", 32'(req_ready_o), 32'd1);
      chk("store_no_wb", 32'(wb_valid_o), 32'd0);
      return;
    end
    repeat (rdly) begin @(posedge clk_i); #1; end
    mem_rvalid_i = 1'b1; mem_rdata_i = rdat;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
    obs_lat = 32'(cyc - c0);
    obs_wb_vld = wb_valid_o; obs_wb_we = wb_we_o; obs_wb_data = wb_data_o;
    chk("load_wb_cycle", 32'(wb_valid_o), 32'd1);
    @(posedge clk_i); #1;
    chk("load_back_idle", 32'(req_ready_o), 32'd1);
    chk("wb_single_cycle", 32'(wb_valid_o), 32'd0);
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic do_timeout(input bit ld);
    int   entry, seen;
    req_t r;
    req_valid_i = 1'b1; req_load_i = ld; funct3_i = 3'b010; addr_i = 32'h40; wdata_i = 32'h1234_5678; rd_i = 5'd4;
    r.addr = 32'h40; r.be = 4'hF; r.we = !ld; r.wdata = 32'h1234_5678;
    exp_req_q.push_back(r);
    exp_err++;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    if (ld) begin
      mem_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0;
    end
    entry = cyc;
    seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      @(posedge clk_i); #1;
      if (err_o) seen = cyc - entry;
    end
    chk(ld ? "timeout_wait_cycles" : "timeout_req_cycles", 32'(seen), 32'(TO));
    chk("timeout_mem_req_low", 32'(mem_req_o), 32'd0);
    chk("timeout_ready", 32'(req_ready_o), 32'd1);
    chk("timeout_no_wb", 32'(wb_valid_o), 32'd0);
    if (!ld && exp_req_q.size() > 0) void'(exp_req_q.pop_front());
    @(posedge clk_i); #1;
    chk("timeout_err_one_cycle", 32'(err_o), 32'd0);
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_load_i = 1'b0; funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0; rd_i = 5'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_vals("reset");
    rst_i = 1'b0;
    chk_en = 1'b1;
    @(posedge clk_i); #1;

    do_op(1'b1, 3'b000, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_1234);
    chk("lb_data", obs_wb_data, 32'hFFFF_FF80);
    chk("lb_we", 32'(obs_wb_we), 32'd1);
    chk("lb_latency", obs_lat, 32'd3);

    do_op(1'b1, 3'b101, 32'h202, 32'h0, 5'd9, 0, 1, 32'hBEEF_0000);
    chk("lhu_data", obs_wb_data, 32'h0000_BEEF);
    do_op(1'b1, 3'b001, 32'h202, 32'h0, 5'd0, 1, 0, 32'hBEEF_0000);
    chk("lh_data", obs_wb_data, 32'hFFFF_BEEF);
    chk("rd0_valid", 32'(obs_wb_vld), 32'd1);
    chk("rd0_we", 32'(obs_wb_we), 32'd0);

    do_op(1'b0, 3'b001, 32'h12, 32'hAAAA_5678, 5'd3, 3, 0, 32'h0);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wdata, 32'h5678_5678);
    chk("sh_addr", obs_addr, 32'h10);
    chk("sh_latency", obs_lat, 32'd5);
    do_op(1'b0, 3'b010, 32'h20, 32'hCAFE_F00D, 5'd1, 0, 0, 32'h0);
    chk("sw_latency", obs_lat, 32'd2);

    do_op(1'b1, 3'b010, 32'h06, 32'h0, 5'd2, 0, 0, 32'h0);
    do_op(1'b1, 3'b011, 32'h40, 32'h0, 5'd2, 0, 0, 32'h0);
    do_op(1'b0, 3'b100, 32'h40, 32'h0, 5'd2, 0, 0, 32'h0);

    // Reset while a load sits in WAIT, then a stray rvalid.
    req_valid_i = 1'b1; req_load_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h80; rd_i = 5'd7;
    cur_req.addr = 32'h80; cur_req.be = 4'hF; cur_req.we = 1'b0; cur_req.wdata = 32'd0;
    exp_req_q.push_back(cur_req);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    chk("wait_busy", 32'(busy_o), 32'd1);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("midreset");
    exp_req_q.delete(); exp_wb_q.delete(); exp_err = 0; last_wb_data = 32'd0; last_wb_rd = 5'd0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_no_wb", 32'(wb_valid_o), 32'd0);
      chk("post_reset_idle", 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0;
    end

`ifdef LSU_TIMEOUT_EN
    do_timeout(1'b0);
    do_timeout(1'b1);
`endif

    for (int n = 0; n < 250; n++) begin
      logic [31:0] ra, rw, rdat;
      logic [2:0]  rf;
      logic [4:0]  rrd;
      bit          rld;
      repeat ($urandom_range(0, 2)) begin
        mem_gnt_i = 1'($urandom_range(0, 1));
        mem_rvalid_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
      end
      ra = $urandom; rw = $urandom; rdat = $urandom;
      rf = 3'($urandom_range(0, 7)); rrd = 5'($urandom_range(0, 31)); rld = 1'($urandom_range(0, 1));
      do_op(rld, rf, ra, rw, rrd, $urandom_range(0, 3), $urandom_range(0, 3), rdat);
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    chk("wb_queue_drained", 32'(exp_wb_q.size()), 32'd0);
    chk("err_all_seen", 32'(exp_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
